beep_sequencer: RTL and testbench

- Command-driven controller that sequences the buzzer tone generator in the radar design.
- Accepts one beep-burst command at a time: tone divider, on-time, off-time and repeat count.
- Drives the tone generator's `key` enable and `div` inputs, producing timed on/off bursts.
- Sits between the distance/alarm logic (the command source) and the tone generator.

---
 rtl/beep_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_beep_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/beep_sequencer.sv
// Beep burst sequencer: turns one {divider, on, off, count} command into timed
// key on/off bursts for the buzzer tone generator, with abort and done reporting.
module beep_sequencer #(
    parameter int CLK_HZ  = 27000000,
    parameter int TICK_HZ = 1000,
    parameter int DIV_W   = 26,
    parameter int DUR_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic [DUR_W-1:0] cmd_on,
    input  logic [DUR_W-1:0] cmd_off,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             key,
    output logic [DIV_W-1:0] div,
    output logic             busy,
    output logic             done
);

    localparam int TICK_CYC = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    logic [1:0]       state_reg,     state_next;
    logic [PRE_W-1:0] presc_reg,     presc_next;
    logic [DUR_W-1:0] on_timer_reg,  on_timer_next;
    logic [DUR_W-1:0] off_timer_reg, off_timer_next;
    logic [DUR_W-1:0] on_len_reg,    on_len_next;
    logic [DUR_W-1:0] off_len_reg,   off_len_next;
    logic [CNT_W-1:0] remain_reg,    remain_next;
    logic [DIV_W-1:0] div_reg,       div_next;
    logic             key_reg,       key_next;
    logic             busy_reg,      busy_next;
    logic             done_reg,      done_next;

    logic tick;
    logic accept;
    logic degenerate;

    assign cmd_ready  = (state_reg == ST_IDLE) && !abort;
    assign accept     = cmd_valid && cmd_ready;
    assign degenerate = (cmd_count == '0) || (cmd_on == '0);
    assign tick       = (presc_reg == PRE_LAST);

    assign key  = key_reg;
    assign div  = div_reg;
    assign busy = busy_reg;
    assign done = done_reg;

    always_comb begin
        state_next     = state_reg;
        on_timer_next  = on_timer_reg;
        off_timer_next = off_timer_reg;
        on_len_next    = on_len_reg;
        off_len_next   = off_len_reg;
        remain_next    = remain_reg;
        div_next       = div_reg;
        key_next       = key_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        // Prescaler only runs during a burst, so every burst starts at phase 0.
        if (state_reg == ST_IDLE) begin
            presc_next = '0;
        end else if (tick) begin
            presc_next = '0;
        end else begin
            presc_next = presc_reg + PRE_W'(1);
        end

        if (abort) begin
            state_next     = ST_IDLE;
            presc_next     = '0;
            on_timer_next  = '0;
            off_timer_next = '0;
            remain_next    = '0;
            key_next       = 1'b0;
            busy_next      = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        div_next     = cmd_div;
                        on_len_next  = cmd_on;
                        off_len_next = cmd_off;
                        presc_next   = '0;
                        if (degenerate) begin
                            done_next = 1'b1;
                        end else begin
                            state_next    = ST_ON;
                            on_timer_next = cmd_on;
                            remain_next   = cmd_count;
                            key_next      = 1'b1;
                            busy_next     = 1'b1;
                        end
                    end
                end

                ST_ON: begin
                    if (tick) begin
                        if (on_timer_reg == DUR_W'(1)) begin
                            remain_next = remain_reg - CNT_W'(1);
                            if (remain_reg == CNT_W'(1)) begin
                                state_next    = ST_IDLE;
                                on_timer_next = '0;
                                key_next      = 1'b0;
                                busy_next     = 1'b0;
                                done_next     = 1'b1;
                            end else if (off_len_reg == '0) begin
                                // Zero gap: stay in ON so key never drops between beeps.
                                on_timer_next = on_len_reg;
                            end else begin
                                state_next     = ST_OFF;
                                on_timer_next  = '0;
                                off_timer_next = off_len_reg;
                                key_next       = 1'b0;
                            end
                        end else begin
                            on_timer_next = on_timer_reg - DUR_W'(1);
                        end
                    end
                end

                ST_OFF: begin
                    if (tick) begin
                        if (off_timer_reg == DUR_W'(1)) begin
                            state_next     = ST_ON;
                            off_timer_next = '0;
                            on_timer_next  = on_len_reg;
                            key_next       = 1'b1;
                        end else begin
                            off_timer_next = off_timer_reg - DUR_W'(1);
                        end
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    key_next   = 1'b0;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= ST_IDLE;
            presc_reg     <= '0;
            on_timer_reg  <= '0;
            off_timer_reg <= '0;
            on_len_reg    <= '0;
            off_len_reg   <= '0;
            remain_reg    <= '0;
            div_reg       <= '0;
            key_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            on_timer_reg  <= on_timer_next;
            off_timer_reg <= off_timer_next;
            on_len_reg    <= on_len_next;
            off_len_reg   <= off_len_next;
            remain_reg    <= remain_next;
            div_reg       <= div_next;
            key_reg       <= key_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer: table of burst commands with hand-computed
// key/done/busy profiles, plus hand-written abort, reset and back-to-back sequences.
module tb_beep_sequencer;

    localparam int DIV_W = 26;
    localparam int DUR_W = 16;
    localparam int CNT_W = 8;
    localparam int WINDOW = 120;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [DIV_W-1:0] cmd_div = '0;
    logic [DUR_W-1:0] cmd_on = '0;
    logic [DUR_W-1:0] cmd_off = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             abort = 1'b0;
    logic             cmd_ready;
    logic             key;
    logic [DIV_W-1:0] div;
    logic             busy;
    logic             done;

    beep_sequencer #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .DIV_W  (DIV_W),
        .DUR_W  (DUR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_div  (cmd_div),
        .cmd_on   (cmd_on),
        .cmd_off  (cmd_off),
        .cmd_count(cmd_count),
        .abort    (abort),
        .key      (key),
        .div      (div),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Expected profile over the window after accept (cycle 1 = first cycle after accept).
    typedef struct {
        int div;
        int on;
        int off;
        int count;
        int exp_high;
        int exp_rises;
        int exp_done_at;
        int exp_busy;
    } vec_t;

    vec_t vecs[6];
    int vec_count  = 0;
    int miss_count = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vec_count++;
        if (act != exp) begin
            miss_count++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic issue(input int d, input int on, input int off, input int cnt);
        @(negedge clk);
        cmd_div   = DIV_W'(d);
        cmd_on    = DUR_W'(on);
        cmd_off   = DUR_W'(off);
        cmd_count = CNT_W'(cnt);
        cmd_valid = 1'b1;
        check("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_vector(input int i);
        int high, rises, done_at, done_n, busy_n, div_bad, ready_bad;
        logic prev_key;
        high = 0; rises = 0; done_at = -1; done_n = 0; busy_n = 0;
        div_bad = 0; ready_bad = 0; prev_key = 1'b0;
        issue(vecs[i].div, vecs[i].on, vecs[i].off, vecs[i].count);
        for (int k = 1; k <= WINDOW; k++) begin
            @(negedge clk);
            if (key) high++;
            if (key && !prev_key) rises++;
            prev_key = key;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (busy) busy_n++;
            if (key && (div != DIV_W'(vecs[i].div))) div_bad++;
            if (busy && cmd_ready) ready_bad++;
        end
        $display("vector %0d: on=%0d off=%0d count=%0d", i, vecs[i].on, vecs[i].off, vecs[i].count);
        check("key_high_cycles", high, vecs[i].exp_high);
        check("key_rises", rises, vecs[i].exp_rises);
        check("done_cycle", done_at, vecs[i].exp_done_at);
        check("done_pulses", done_n, 1);
        check("busy_cycles", busy_n, vecs[i].exp_busy);
        check("div_while_key_bad", div_bad, 0);
        check("ready_while_busy", ready_bad, 0);
    endtask

    initial begin
        int done_n, high;

        vecs[0] = '{5, 3, 2, 1, 30, 1, 31, 30};   // single beep
        vecs[1] = '{7, 2, 1, 3, 60, 3, 81, 80};   // 20/10/20/10/20
        vecs[2] = '{9, 1, 0, 4, 40, 1, 41, 40};   // continuous, no gap
        vecs[3] = '{3, 5, 1, 0, 0, 0, 1, 0};      // count = 0
        vecs[4] = '{3, 0, 2, 2, 0, 0, 1, 0};      // on = 0
        vecs[5] = '{12, 1, 3, 2, 20, 2, 51, 50};  // 10/30/10

        #1;
        check("rst_key", key, 0);
        check("rst_div", div, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        #1 check("rst_ready_after_release", cmd_ready, 1);

        for (int i = 0; i < 6; i++) run_vector(i);

        // Abort at clock 15 of a count=3 burst
        issue(4, 2, 1, 3);
        for (int k = 1; k <= 15; k++) @(negedge clk);
        check("abort_key_before", key, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_key", key, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        done_n = 0; high = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) done_n++;
            if (key) high++;
        end
        check("abort_no_done", done_n, 0);
        check("abort_no_key", high, 0);

        // Abort held in IDLE blocks acceptance
        @(negedge clk);
        abort = 1'b1;
        cmd_div = DIV_W'(2); cmd_on = DUR_W'(3); cmd_off = DUR_W'(1); cmd_count = CNT_W'(1);
        cmd_valid = 1'b1;
        #1 check("abort_idle_ready", cmd_ready, 0);
        done_n = 0; high = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_n++;
            if (key || busy) high++;
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
        check("abort_idle_no_accept", high, 0);
        check("abort_idle_no_done", done_n, 0);

        // Final expiry and abort together: abort wins, no done
        issue(2, 1, 0, 1);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("expiry_abort_done", done, 0);
        check("expiry_abort_key", key, 0);
        check("expiry_abort_busy", busy, 0);

        // New command accepted in the cycle done pulses
        issue(6, 1, 0, 1);
        for (int k = 1; k <= 11; k++) @(negedge clk);
        check("b2b_done", done, 1);
        check("b2b_ready", cmd_ready, 1);
        cmd_div = DIV_W'(8); cmd_on = DUR_W'(1); cmd_off = DUR_W'(0); cmd_count = CNT_W'(2);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_key", key, 1);
        check("b2b_busy", busy, 1);
        check("b2b_div", div, 8);
        done_n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("b2b_done_once", done_n, 1);

        // Reset mid-burst drops key immediately and discards the burst
        issue(11, 5, 1, 2);
        for (int k = 0; k < 5; k++) @(negedge clk);
        check("midrst_key_before", key, 1);
        #2 nrst = 1'b0;
        #1;
        check("midrst_key", key, 0);
        check("midrst_busy", busy, 0);
        check("midrst_div", div, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        nrst = 1'b1;
        #1 check("midrst_ready", cmd_ready, 1);
        high = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (key || busy) high++;
        end
        check("midrst_burst_gone", high, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
